hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core; sits beside the ID/EX boundary.
//  Tracks the destination registers of in-flight instructions in a shadow EX/MEM/WB pipe.
//  Detects RAW and load-use hazards and issues stall, bubble and flush controls.
//  Drives the registered forwarding selects used by the execute-stage ALU operand muxes.
// PARAMETERS
//  REG_ADDR_W   5   register-address width (rs/rt/dest)
//  STALL_CNT_W  16  width of saturating stall-cycle counter
// PORTS
//  clk               in   1            pipeline clock, all state on posedge
//  reset             in   1            synchronous, active-high
//  id_valid          in   1            ID holds a real instruction
//  id_rs             in   REG_ADDR_W   source reg A of ID instruction
//  id_rt             in   REG_ADDR_W   source reg B of ID instruction
//  id_uses_rs        in   1            ID instruction reads rs
//  id_uses_rt        in   1            ID instruction reads rt
//  id_reg_write      in   1            ID instruction writes a register
//  id_mem_read       in   1            ID instruction is a load
//  id_write_register in   REG_ADDR_W   decoded dest (after regDest mux)
//  ex_branch_taken   in   1            branch resolved taken in EX this cycle
//  pc_write_en       out  1            PC may update
//  if_id_write_en    out  1            IF/ID register may load
//  if_id_flush       out  1            IF/ID cleared to NOP
//  id_ex_bubble      out  1            ID/EX loads a bubble (all ctrl 0)
//  forward_a         out  2            ALU input1 sel: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  forward_b         out  2            ALU input2 (pre-aluSrc) sel, same encoding
//  stall_count       out  STALL_CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Reset (sync, while reset=1): shadow slots invalid, FSM=RUN, stall_count=0,
//   forward_a/b=00; outputs forced pc_write_en=0, if_id_write_en=0, if_id_flush=1,
//   id_ex_bubble=1. First cycle after reset deassert: normal RUN outputs.
//  Shadow pipe: slots EX,MEM,WB each {valid,reg_write,mem_read,dest}; every cycle
//   MEM<=EX, WB<=MEM; EX<=ID fields if id_valid && !id_ex_bubble, else invalid.
//  match(slot,r): slot.valid && slot.reg_write && slot.dest==r && r!=0; a source
//   counts only if its id_uses_* is set. $0 never hazards. WB slot never hazards
//   (regfile writes first half, reads second half).
//  FSM states: RUN, STALL.
//   RUN: no hazard -> pc_write_en=1, if_id_write_en=1, flush=0, bubble=0.
//   hazard detected -> enter STALL same cycle: pc_write_en=0, if_id_write_en=0,
//    id_ex_bubble=1; stall_count+1 (saturates at all-ones, no wrap).
//   STALL: re-evaluates each cycle; remains while hazard persists, returns to RUN
//    the cycle hazard clears (outputs of RUN that cycle).
//  Branch: ex_branch_taken=1 overrides everything: pc_write_en=1, if_id_write_en=1,
//   if_id_flush=1, id_ex_bubble=1, FSM->RUN, no stall counted, forward_a/b<=00.
//  Simultaneous branch+hazard: branch wins; hazard discarded (instr is flushed).
//  Forward regs: updated only when ID/EX advances (no stall); held during stall;
//   EX-slot match has priority over MEM-slot match (10 beats 01).
//  Latency: hazard decision combinational from inputs+shadow; forward sel 1 cycle.
// CONFIGURATION
//  HAZARD_FORWARD_EN defined: hazard = EX slot mem_read && match(EX, rs|rt)
//   (load-use, 1 stall cycle); forwarding per rules above.
//  HAZARD_FORWARD_EN undefined: hazard = match(EX|MEM, rs|rt) (stall 1-2 cycles
//   until producer reaches WB); forward_a/b constant 00.
// TESTING
//  T1 reset 3 cycles -> outputs at reset values; 1st cycle after: pc_we=1, bubble=0, cnt=0.
//  T2 FWD_EN: ID add dest=8, next ID sub rs=8 -> no stall, forward_a=10 in sub's EX.
//  T3 FWD_EN: ID lw dest=9, next ID add rt=9 -> 1 stall cycle (pc_we=0, bubble=1,
//   cnt=1), then forward_b=01.
//  T4 no FWD_EN: add dest=5 then or rs=5 -> 2 stall cycles, cnt=2, forward=00.
//  T5 lw dest=7 then use rs=7 with ex_branch_taken=1 same cycle -> flush=1, bubble=1,
//   pc_we=1, cnt unchanged; dest=0 producer then rs=0 consumer -> no stall.
//  T6 STALL_CNT_W=2, force 5 stall cycles -> stall_count saturates at 3.

Source files
------------

// File: rtl/hazard_controller_if.sv
// ID-stage instruction fields into the hazard controller and pipeline controls back out.
// Master is the pipeline/decoder side; slave is the hazard controller.
interface hazard_controller_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  id_rs;
    logic [REG_ADDR_W-1:0]  id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic                   id_reg_write;
    logic                   id_mem_read;
    logic [REG_ADDR_W-1:0]  id_write_register;
    logic                   ex_branch_taken;

    logic                   pc_write_en;
    logic                   if_id_write_en;
    logic                   if_id_flush;
    logic                   id_ex_bubble;
    logic [1:0]             forward_a;
    logic [1:0]             forward_b;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_mem_read, id_write_register, ex_branch_taken,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               forward_a, forward_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_mem_read, id_write_register, ex_branch_taken,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               forward_a, forward_b, stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// RAW/load-use hazard sequencer and forwarding select for the 5-stage core (HAZARD_FORWARD_EN enables forwarding).
// Latency: stall/bubble/flush combinational from ID + shadow pipe; forward selects registered, 1 cycle.
// Backpressure: a hazard holds PC and IF/ID and injects a bubble into ID/EX; a taken branch overrides.
module hazard_controller #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_controller_if.slave hif
);

    typedef logic [REG_ADDR_W-1:0] reg_t;

    // An instruction leaving MEM has already written the regfile before ID reads it,
    // so only the EX and MEM shadow slots can ever produce a hazard or a forward.
    typedef struct packed {
        logic wr;
        reg_t dest;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    slot_t                  ex_q, ex_d;
    slot_t                  mem_q, mem_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic hazard;
    logic stall;
    logic pc_we;
    logic ifid_we;
    logic flush;
    logic bubble;

    function automatic logic hit(input slot_t s, input reg_t r, input logic used);
        return used && s.wr && (s.dest == r) && (r != '0);
    endfunction

`ifdef HAZARD_FORWARD_EN
    logic       ex_ld_q, ex_ld_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                           input reg_t r, input logic used);
        if (hit(ex, r, used))       return 2'b10;
        else if (hit(mem, r, used)) return 2'b01;
        else                        return 2'b00;
    endfunction
`endif

    always_comb begin : hazard_detect
        hazard = 1'b0;
        if (hif.id_valid) begin
`ifdef HAZARD_FORWARD_EN
            hazard = ex_ld_q && (hit(ex_q, hif.id_rs, hif.id_uses_rs) ||
                                 hit(ex_q, hif.id_rt, hif.id_uses_rt));
`else
            hazard = hit(ex_q,  hif.id_rs, hif.id_uses_rs) || hit(ex_q,  hif.id_rt, hif.id_uses_rt) ||
                     hit(mem_q, hif.id_rs, hif.id_uses_rs) || hit(mem_q, hif.id_rt, hif.id_uses_rt);
`endif
        end
    end

    // A taken branch flushes the ID instruction, so its hazard is moot.
    assign stall = hazard && !hif.ex_branch_taken;

    always_comb begin : next_state
        state_d = stall ? STALL : RUN;
    end

    always_comb begin : fsm_outputs
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        if (reset) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            flush   = 1'b1;
            bubble  = 1'b1;
        end else if (hif.ex_branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        bubble  = 1'b1;
                    end
                end
                STALL: begin
                    if (hazard) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        bubble  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin : datapath_next
        ex_d.wr   = hif.id_valid && !bubble && hif.id_reg_write;
        ex_d.dest = hif.id_write_register;
        mem_d     = ex_q;
        cnt_d     = cnt_q;
        if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
`ifdef HAZARD_FORWARD_EN
        ex_ld_d = hif.id_valid && !bubble && hif.id_mem_read;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (hif.ex_branch_taken) begin
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
        end else if (!stall) begin
            fwd_a_d = fwd_sel(ex_q, mem_q, hif.id_rs, hif.id_uses_rs);
            fwd_b_d = fwd_sel(ex_q, mem_q, hif.id_rt, hif.id_uses_rt);
        end
`endif
    end

    always_ff @(posedge clk) begin : state_regs
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
`ifdef HAZARD_FORWARD_EN
            ex_ld_q <= 1'b0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
`ifdef HAZARD_FORWARD_EN
            ex_ld_q <= ex_ld_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
`endif
        end
    end

    assign hif.pc_write_en    = pc_we;
    assign hif.if_id_write_en = ifid_we;
    assign hif.if_id_flush    = flush;
    assign hif.id_ex_bubble   = bubble;
    assign hif.stall_count    = cnt_q;
`ifdef HAZARD_FORWARD_EN
    assign hif.forward_a      = fwd_a_q;
    assign hif.forward_b      = fwd_b_q;
`else
    assign hif.forward_a      = 2'b00;
    assign hif.forward_b      = 2'b00;
`endif

endmodule
